// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and digit helpers for the BCD counter family.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO = 4'd0;
  localparam bcd_digit_t BCD_MAX  = 4'd9;

  // Non-decimal codes A-F are pulled down to the largest legal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
    return (d == BCD_ZERO) ? BCD_MAX : bcd_digit_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle between a BCD down-counter and the logic that drives it.
interface bcd_down_counter_if #(
  parameter int DIGITS = 4
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  enable;
  logic [4*DIGITS-1:0]   count;
  logic                  borrow;
  logic                  zero;

  modport master (
    output load,
    output load_value,
    output enable,
    input  count,
    input  borrow,
    input  zero
  );

  modport slave (
    input  load,
    input  load_value,
    input  enable,
    output count,
    output borrow,
    output zero
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit register: clamped parallel load, or decrement with 0 -> 9 borrow wrap.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_in,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       is_zero
);

  bcd_digit_t digit_d;
  bcd_digit_t digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(load_digit);
    end else if (dec_in) begin
      digit_d = bcd_dec(digit_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with registered borrow and zero flags.
// Define BCD_DOWN_SATURATE_EN to stop at zero instead of wrapping to all nines.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  bcd_down_counter_if.slave   bus
);

`ifdef BCD_DOWN_SATURATE_EN
  localparam bit SATURATE_EN = 1'b1;
`else
  localparam bit SATURATE_EN = 1'b0;
`endif

  logic [4*DIGITS-1:0] count_w;
  logic [DIGITS-1:0]   dig_zero;
  logic [DIGITS-1:0]   dig_dec;
  logic                upper_zero;
  logic                all_zero;
  logic                count_is_one;
  logic                dec_go;
  logic                run;
  logic                borrow_d;
  logic                borrow_q;
  logic                zero_d;
  logic                zero_q;

  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      upper_zero = upper_zero & dig_zero[i];
    end
    all_zero     = upper_zero & dig_zero[0];
    count_is_one = upper_zero & (count_w[3:0] == 4'd1);
  end

  // A digit steps only when every lower digit is zero; saturate mode freezes the whole chain at zero.
  always_comb begin
    dec_go = bus.enable & ~bus.load & ~(SATURATE_EN & all_zero);
    run    = dec_go;
    dig_dec = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_dec[i] = run;
      run        = run & dig_zero[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .dec_in     (dig_dec[i]),
      .load       (bus.load),
      .load_digit (bus.load_value[4*i +: 4]),
      .digit      (count_w[4*i +: 4]),
      .is_zero    (dig_zero[i])
    );
  end

  // Clamping never turns a nonzero digit into zero, so the raw load value decides the zero flag.
  always_comb begin
    borrow_d = 1'b0;
    zero_d   = zero_q;
    if (bus.load) begin
      zero_d = (bus.load_value == '0);
    end else if (bus.enable) begin
      borrow_d = ~SATURATE_EN & all_zero;
      zero_d   = count_is_one | (SATURATE_EN & all_zero);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.count  = count_w;
  assign bus.borrow = borrow_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter (DIGITS=4): decimal reference model plus directed and random stimulus.
// Honours BCD_DOWN_SATURATE_EN the same way as the design.
module tb_bcd_down_counter;

`ifdef BCD_DOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  int   model_val;
  bit   model_borrow;
  bit   model_valid;

  bcd_down_counter_if #(.DIGITS(4)) bus ();

  bcd_down_counter #(.DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampToDec(input logic [15:0] v);
    int acc;
    int scale;
    int d;
    acc   = 0;
    scale = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'((v >> (4*i)) & 16'hF);
      if (d > 9) d = 9;
      acc   = acc + d * scale;
      scale = scale * 10;
    end
    return acc;
  endfunction

  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model works on the decimal value, not on digits.
  always @(posedge clk) begin
    if (reset) begin
      model_val    = 0;
      model_borrow = 1'b0;
      model_valid  = 1'b1;
    end else if (model_valid) begin
      model_borrow = 1'b0;
      if (bus.load) begin
        model_val = clampToDec(bus.load_value);
      end else if (bus.enable) begin
        if (model_val == 0) begin
          if (!SAT) begin
            model_val    = 9999;
            model_borrow = 1'b1;
          end
        end else begin
          model_val = model_val - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      compared++;
      if (bus.count !== toBcd(model_val)) begin
        mismatched++;
        $display("[TB] FAIL model_count @%0t: got %h expected %h", $time, bus.count, toBcd(model_val));
      end
      compared++;
      if (bus.borrow !== model_borrow) begin
        mismatched++;
        $display("[TB] FAIL model_borrow @%0t: got %b expected %b", $time, bus.borrow, model_borrow);
      end
      compared++;
      if (bus.zero !== (model_val == 0)) begin
        mismatched++;
        $display("[TB] FAIL model_zero @%0t: got %b expected %b", $time, bus.zero, (model_val == 0));
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] val, input logic en);
    reset          = rst;
    bus.load       = ld;
    bus.load_value = val;
    bus.enable     = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] exp_count, input logic exp_borrow, input logic exp_zero);
    compared++;
    if (bus.count !== exp_count || bus.borrow !== exp_borrow || bus.zero !== exp_zero) begin
      mismatched++;
      $display("[TB] FAIL %s: got count=%h borrow=%b zero=%b expected count=%h borrow=%b zero=%b",
               name, bus.count, bus.borrow, bus.zero, exp_count, exp_borrow, exp_zero);
    end
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    model_val      = 0;
    model_borrow   = 1'b0;
    model_valid    = 1'b0;
    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.enable     = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("reset", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("idle_after_reset", 16'h0000, 1'b0, 1'b1);
    end

    applyStimulus(1'b0, 1'b1, 16'h1000, 1'b0);
    checkOutput("load_1000", 16'h1000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("borrow_chain_0999", 16'h0999, 1'b0, 1'b0);
    for (int i = 0; i < 998; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("count_0001", 16'h0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("count_to_zero", 16'h0000, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
    checkOutput("load_zero", 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
`ifdef BCD_DOWN_SATURATE_EN
    checkOutput("saturate_hold", 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("saturate_idle", 16'h0000, 1'b0, 1'b1);
`else
    checkOutput("underflow_wrap", 16'h9999, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("borrow_one_cycle", 16'h9999, 1'b0, 1'b0);
`endif

    applyStimulus(1'b0, 1'b1, 16'h0A5F, 1'b0);
    checkOutput("clamp_0A5F", 16'h0959, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0042, 1'b1);
    checkOutput("load_beats_enable", 16'h0042, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 16'h0050, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("count_0047", 16'h0047, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    checkOutput("reset_mid_count", 16'h0000, 1'b0, 1'b1);

    // Random phase: small loads often so underflow and the zero boundary get exercised.
    for (int i = 0; i < 4000; i++) begin
      logic        r_rst;
      logic        r_ld;
      logic        r_en;
      logic [15:0] r_val;
      r_rst = ($urandom_range(99) < 2);
      r_ld  = ($urandom_range(99) < 10);
      r_en  = ($urandom_range(99) < 70);
      if ($urandom_range(1) == 0) r_val = 16'($urandom_range(3));
      else                        r_val = 16'($urandom);
      applyStimulus(r_rst, r_ld, r_val, r_en);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
